// File: rtl/prbs_pkg.sv
// prbs_pkg: definitions shared by the PRBS checker and the generator side.
//   - FSM state encoding of the checker (SEEK / VERIFY / LOCKED)
//   - tap mask of the 8-bit polynomial x^8+x^6+x^5+x^4+1
//   - lfsr_next(): one LFSR step, used by both ends so the sequences stay
//     bit-identical.
package prbs_pkg;

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Bits 7,5,4,3 feed the XOR that becomes the new LSB.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift left, new bit 0 = parity of the tapped bits. Period 255; the
    // all-zero word maps onto itself and is never a valid seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears q
//   clr  : synchronous clear (wins over inc)
//   inc  : count one event this cycle
//   q    : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 8-bit PRBS data path.
// It seeds a predictor from a received nonzero word, verifies LOCK_COUNT
// consecutive predictions, then free-runs the predictor and counts
// mismatches. UNLOCK_THRESH consecutive mismatches drop lock (sticky loss).
//
// Handshake: data_valid qualifies data_in for exactly one word per cycle;
// there is no ready/backpressure, every valid word is consumed.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous; zeroes counters and loss, returns to SEEK,
//                discards a word presented in the same cycle
//   data_valid : data_in holds a word this cycle
//   data_in    : received word
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per mismatched word while locked
//   loss       : sticky, lock was lost since last rst/clear
//   err_cnt    : mismatches while locked (saturating)
//   word_cnt   : words checked while locked (saturating)
//   expected   : prediction for the next valid word
//   state_dbg  : current FSM state (prbs_pkg encoding)
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             loss,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_THRESH);

    logic [1:0] state;
    logic [3:0] match_cnt;
    logic [3:0] consec_err;
    logic       word_inc;
    logic       err_inc;
    logic       mismatch;

    assign mismatch  = (data_in != expected);
    assign word_inc  = data_valid && !clear && (state == ST_LOCKED);
    assign err_inc   = word_inc && mismatch;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SEEK;
            expected   <= '0;
            match_cnt  <= '0;
            consec_err <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            loss       <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                state      <= ST_SEEK;
                match_cnt  <= '0;
                consec_err <= '0;
                locked     <= 1'b0;
                loss       <= 1'b0;
            end else if (data_valid) begin
                case (state)
                    ST_SEEK: begin
                        // Zero is the LFSR lockup value and cannot seed.
                        if (data_in != '0) begin
                            expected  <= lfsr_next(data_in);
                            match_cnt <= '0;
                            state     <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (!mismatch) begin
                            expected  <= lfsr_next(expected);
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_LAST) begin
                                state      <= ST_LOCKED;
                                locked     <= 1'b1;
                                consec_err <= '0;
                            end
                        end else if (data_in != '0) begin
                            expected  <= lfsr_next(data_in);
                            match_cnt <= '0;
                        end else begin
                            state <= ST_SEEK;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on our own state so a corrupted word
                        // does not corrupt later predictions.
                        expected <= lfsr_next(expected);
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (consec_err + 4'd1 == UNLOCK_LAST) begin
                                state      <= ST_SEEK;
                                locked     <= 1'b0;
                                loss       <= 1'b1;
                                consec_err <= '0;
                            end else begin
                                consec_err <= consec_err + 4'd1;
                            end
                        end else begin
                            consec_err <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_SEEK;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_inc),
        .q   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (word_inc),
        .q   (word_cnt)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios followed by random traffic,
// all checked against a behavioural model. A second instance with 4-bit
// counters shares every input so counter saturation is reached quickly.
module tb_prbs_checker;

    localparam int M_SEEK = 0, M_VERIFY = 1, M_LOCKED = 2;
    localparam int LOCK_N = 4, UNLOCK_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        locked, err_pulse, loss;
    logic [15:0] err_cnt, word_cnt;
    logic [7:0]  expected;
    logic [1:0]  state_dbg;
    logic        s_locked, s_err_pulse, s_loss;
    logic [3:0]  s_err_cnt, s_word_cnt;
    logic [7:0]  s_expected;
    logic [1:0]  s_state_dbg;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int          m_mode;
    logic [7:0]  m_exp;
    int          m_run, m_bad;
    int unsigned m_err, m_words;
    bit          m_loss, m_pulse;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid),
        .data_in(data_in), .locked(locked), .err_pulse(err_pulse),
        .loss(loss), .err_cnt(err_cnt), .word_cnt(word_cnt),
        .expected(expected), .state_dbg(state_dbg)
    );

    prbs_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .data_valid(data_valid),
        .data_in(data_in), .locked(s_locked), .err_pulse(s_err_pulse),
        .loss(s_loss), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt),
        .expected(s_expected), .state_dbg(s_state_dbg)
    );

    // Polynomial x^8+x^6+x^5+x^4+1: shift left, new LSB from bits 7,5,4,3.
    function automatic logic [7:0] nxt(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_mode = M_SEEK; m_exp = 8'h00; m_run = 0; m_bad = 0;
        m_err = 0; m_words = 0; m_loss = 0; m_pulse = 0;
    endtask

    task automatic model_apply(input bit c, input bit v, input logic [7:0] d);
        m_pulse = 0;
        if (c) begin
            m_mode = M_SEEK; m_run = 0; m_bad = 0;
            m_err = 0; m_words = 0; m_loss = 0;
        end else if (v) begin
            if (m_mode == M_SEEK) begin
                if (d != 0) begin m_exp = nxt(d); m_run = 0; m_mode = M_VERIFY; end
            end else if (m_mode == M_VERIFY) begin
                if (d == m_exp) begin
                    m_exp = nxt(m_exp);
                    m_run++;
                    if (m_run == LOCK_N) begin m_mode = M_LOCKED; m_bad = 0; end
                end else if (d != 0) begin
                    m_exp = nxt(d); m_run = 0;
                end else begin
                    m_mode = M_SEEK;
                end
            end else begin
                m_words++;
                if (d != m_exp) begin m_pulse = 1; m_err++; m_bad++; end
                else m_bad = 0;
                m_exp = nxt(m_exp);
                if (m_bad == UNLOCK_N) begin m_mode = M_SEEK; m_loss = 1; m_bad = 0; end
            end
        end
    endtask

    task automatic compare_all();
        chk("locked",    locked,    (m_mode == M_LOCKED));
        chk("err_pulse", err_pulse, m_pulse);
        chk("loss",      loss,      m_loss);
        chk("err_cnt",   err_cnt,   sat(m_err, 16'hFFFF));
        chk("word_cnt",  word_cnt,  sat(m_words, 16'hFFFF));
        chk("expected",  expected,  m_exp);
        chk("state",     state_dbg, m_mode);
        chk("s_err_cnt", s_err_cnt, sat(m_err, 4'hF));
        chk("s_word_cnt", s_word_cnt, sat(m_words, 4'hF));
    endtask

    task automatic step(input bit c, input bit v, input logic [7:0] d);
        clear = c; data_valid = v; data_in = d;
        @(posedge clk);
        model_apply(c, v, d);
        #1;
        compare_all();
    endtask

    task automatic feed_lock_seq();
        step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04);
        step(0, 1, 8'h08); step(0, 1, 8'h11);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // reset state
        chk("rst_locked", locked, 0);   chk("rst_loss", loss, 0);
        chk("rst_pulse", err_pulse, 0); chk("rst_err", err_cnt, 0);
        chk("rst_words", word_cnt, 0);  chk("rst_exp", expected, 0);
        chk("rst_state", state_dbg, M_SEEK);

        // lock on 01,02,04,08,11
        step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04); step(0, 1, 8'h08);
        chk("pre_lock", locked, 0);
        step(0, 1, 8'h11);
        chk("lock", locked, 1); chk("lock_exp", expected, 8'h23);
        chk("lock_err", err_cnt, 0); chk("lock_words", word_cnt, 0);

        // single error: 24 (expected 23), then 47, 8E
        step(0, 1, 8'h24);
        chk("se_pulse", err_pulse, 1);
        step(0, 1, 8'h47);
        chk("se_pulse_end", err_pulse, 0);
        step(0, 1, 8'h8E);
        chk("se_err", err_cnt, 1); chk("se_words", word_cnt, 3);
        chk("se_locked", locked, 1); chk("se_exp", expected, 8'h1C);

        // gap holds state
        step(0, 0, 8'h99);
        chk("gap_exp", expected, 8'h1C);

        // clear together with a valid word while locked
        step(1, 1, 8'h1C);
        chk("clr_err", err_cnt, 0); chk("clr_words", word_cnt, 0);
        chk("clr_loss", loss, 0); chk("clr_state", state_dbg, M_SEEK);

        // loss of lock
        feed_lock_seq();
        for (int i = 0; i < 4; i++) step(0, 1, m_exp ^ 8'hFF);
        chk("loss_err", err_cnt, 4); chk("loss_locked", locked, 0);
        chk("loss_flag", loss, 1); chk("loss_state", state_dbg, M_SEEK);
        feed_lock_seq();
        chk("relock", locked, 1); chk("relock_loss", loss, 1);

        // zero and reseed
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        chk("zero_state", state_dbg, M_SEEK);
        step(0, 1, 8'h01); step(0, 1, 8'h02);
        step(0, 1, 8'h55);
        chk("reseed_exp", expected, 8'hAB);
        step(0, 1, 8'hAB);
        chk("reseed_match_exp", expected, 8'h57);
        chk("reseed_state", state_dbg, M_VERIFY);

        // finish locking, then drive the 4-bit counters into saturation
        for (int i = 0; i < 3; i++) step(0, 1, m_exp);
        chk("lock2", locked, 1);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 3; i++) step(0, 1, m_exp ^ 8'h3C);
            step(0, 1, m_exp);
        end
        chk("sat_err_small", s_err_cnt, 4'hF);
        chk("sat_err_main", err_cnt, 18);
        step(0, 1, m_exp ^ 8'h01);
        chk("sat_hold_small", s_err_cnt, 4'hF);
        chk("sat_words_small", s_word_cnt, 4'hF);
        chk("sat_err_main2", err_cnt, 19);

        // asynchronous reset while locked with err_pulse high
        chk("pre_rst_pulse", err_pulse, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_locked", locked, 0); chk("arst_pulse", err_pulse, 0);
        chk("arst_err", err_cnt, 0);   chk("arst_exp", expected, 0);
        #1 rst = 1'b0;
        data_valid = 1'b0; clear = 1'b0;
        model_reset();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       step(1, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (r < 12) step(0, 0, 8'($urandom));
            else if (r < 20) step(0, 1, 8'($urandom));
            else if (r < 23) step(0, 1, 8'h00);
            else             step(0, 1, m_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
